// File: rtl/stopwatch_pkg.sv
// Shared types and the 7-segment decoder for the stopwatch datapath.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_t;
    // {m1,m0,s1,s0,c1,c0}; element 0 is the rightmost centisecond digit
    typedef bcd_t [NUM_DIGITS-1:0] time_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit
    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_ZERO;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_timer_digit.sv
// One BCD digit of the time counter; counts 0..MAX, carry is combinational
// so a whole chain rolls over in a single cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output bcd_t q_o,
    output logic carry_o
);

    localparam bcd_t MAX_V = bcd_t'(MAX);

    bcd_t q;

    assign carry_o = inc_i && (q == MAX_V);
    assign q_o     = q;

    // digit register: clear wins, otherwise step and wrap at MAX
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr_i)
            q <= '0;
        else if (inc_i)
            q <= (q == MAX_V) ? '0 : q + 4'd1;
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Stopwatch datapath: prescaled BCD mm:ss:cc counter, split/shadow register
// and a multiplexed 6-digit active-low 7-segment driver.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        update_i,
    input  logic        clr_i,
    output logic [23:0] time_o,
    output logic        tick_o,
    output logic        wrap_o,
    output logic [5:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int PSC_W = $clog2(TICK_DIV);
    localparam int SCN_W = $clog2(SCAN_DIV);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_DIV - 1);

    logic [PSC_W-1:0]    psc;
    logic [SCN_W-1:0]    scan_cnt;
    logic [2:0]          scan_idx;
    logic                tick_now;
    logic [NUM_DIGITS:0] carry;
    time_t               cnt;
    time_t               shadow;

    // clear suppresses the tick so no advance happens on the clearing edge
    assign tick_now = en_i && !clr_i && (psc == PSC_LAST);
    assign carry[0] = tick_now;

    // counter chain c0,c1,s0,s1,m0,m1; tens of seconds/minutes stop at 5
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        localparam int DMAX = (k == 3 || k == 5) ? 5 : 9;
        bcd_digit #(.MAX(DMAX)) u_dig (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (clr_i),
            .inc_i   (carry[k]),
            .q_o     (cnt[k]),
            .carry_o (carry[k+1])
        );
    end

    // prescaler: pausing keeps the partial tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            psc <= '0;
        else if (clr_i)
            psc <= '0;
        else if (en_i)
            psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
    end

    // event pulses, aligned with the counter value they report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            tick_o <= tick_now;
            wrap_o <= carry[NUM_DIGITS];
        end
    end

    // shadow copy of the counter; frozen while update_i is low (split view)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= '0;
        else if (clr_i)
            shadow <= '0;
        else if (update_i)
            shadow <= cnt;
    end

    assign time_o = shadow;

    // free-running digit scan, unaffected by the stopwatch controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // registered display drive for the currently selected digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_o  <= 6'b111110;
            seg_o <= SEG_ZERO;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= ~(6'b000001 << scan_idx);
            seg_o <= seg_decode(shadow[scan_idx]);
            dp_o  <= !(scan_idx == 3'd2 || scan_idx == 3'd4);
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Randomized bench for stopwatch_timer against a centisecond-count model.
module tb_stopwatch_timer;

    localparam int TD   = 4;
    localparam int SD   = 2;
    localparam int FULL = 360000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b0;
    logic        update_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [23:0] time_o;
    logic        tick_o;
    logic        wrap_o;
    logic [5:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [23:0] preset_v = '0;

    stopwatch_timer #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_i),
        .update_i (update_i),
        .clr_i    (clr_i),
        .time_o   (time_o),
        .tick_o   (tick_o),
        .wrap_o   (wrap_o),
        .an_o     (an_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model: time as plain centiseconds since 00:00:00
    int         m_total;
    int         m_psc;
    int         m_shadow;
    int         m_scan;
    bit         m_tick;
    bit         m_wrap;
    logic [5:0] m_an;
    logic [6:0] m_seg;
    bit         m_dp;

    logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int digit_of(input int t, input int i);
        case (i)
            0:       return t % 10;
            1:       return (t / 10) % 10;
            2:       return (t / 100) % 10;
            3:       return ((t / 100) % 60) / 10;
            4:       return (t / 6000) % 10;
            default: return (t / 6000) / 10;
        endcase
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        logic [23:0] r = '0;
        for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'(digit_of(t, i));
        return r;
    endfunction

    task automatic model_reset();
        m_total = 0; m_psc = 0; m_shadow = 0; m_scan = 0;
        m_tick = 0; m_wrap = 0;
        m_an = 6'b111110; m_seg = 7'b1000000; m_dp = 1;
    endtask

    // one clock edge worth of behaviour, using values from before the edge
    task automatic model_edge();
        int idx;
        idx    = (m_scan / SD) % 6;
        m_an   = 6'b111111 ^ (6'b000001 << idx);
        m_seg  = seg_lut[digit_of(m_shadow, idx)];
        m_dp   = !(idx == 2 || idx == 4);
        m_scan = (m_scan + 1) % (6 * SD);
        m_tick = 0;
        m_wrap = 0;
        if (clr_i) begin
            m_total = 0; m_psc = 0; m_shadow = 0;
        end else begin
            if (update_i) m_shadow = m_total;
            if (en_i) begin
                if (m_psc == TD - 1) begin
                    m_psc = 0;
                    m_tick = 1;
                    m_total++;
                    if (m_total == FULL) begin
                        m_total = 0;
                        m_wrap = 1;
                    end
                end else begin
                    m_psc++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("time", time_o, to_bcd(m_shadow));
        chk("tick", tick_o, m_tick);
        chk("wrap", wrap_o, m_wrap);
        chk("an",   an_o,   m_an);
        chk("seg",  seg_o,  m_seg);
        chk("dp",   dp_o,   m_dp);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // load the counter directly (counter paused, shadow frozen); model follows
    task automatic preset(input int t);
        en_i = 0;
        update_i = 0;
        preset_v = to_bcd(t);
        force dut.g_dig[0].u_dig.q = preset_v[3:0];
        force dut.g_dig[1].u_dig.q = preset_v[7:4];
        force dut.g_dig[2].u_dig.q = preset_v[11:8];
        force dut.g_dig[3].u_dig.q = preset_v[15:12];
        force dut.g_dig[4].u_dig.q = preset_v[19:16];
        force dut.g_dig[5].u_dig.q = preset_v[23:20];
        m_total = t;
        cycle();
        release dut.g_dig[0].u_dig.q;
        release dut.g_dig[1].u_dig.q;
        release dut.g_dig[2].u_dig.q;
        release dut.g_dig[3].u_dig.q;
        release dut.g_dig[4].u_dig.q;
        release dut.g_dig[5].u_dig.q;
    endtask

    initial begin
        int  nt;
        bit  found;

        // reset state
        #12;
        chk("rst_time", time_o, 24'h0);
        chk("rst_tick", tick_o, 1'b0);
        chk("rst_wrap", wrap_o, 1'b0);
        chk("rst_an",   an_o,   6'b111110);
        chk("rst_seg",  seg_o,  7'b1000000);
        chk("rst_dp",   dp_o,   1'b1);
        @(negedge clk);
        rst = 0;
        model_reset();

        // 1: 400 clk -> 100 ticks, 00:01.00 shown one cycle after the last one
        en_i = 1; update_i = 1;
        nt = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (tick_o) nt++;
        end
        chk("t1_ticks", nt, 100);
        cycle();
        chk("t1_time", time_o, 24'h000100);

        // 3: split hold at 00:00.50
        clr_i = 1; cycle(); clr_i = 0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cycle();
            if (m_total == 50) found = 1;
        end
        chk("t3_reach", found, 1'b1);
        cycle();
        chk("t3_split", time_o, 24'h000050);
        update_i = 0;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            chk("t3_frozen", time_o, 24'h000050);
            if (tick_o) nt++;
        end
        chk("t3_ticks", nt, 10);
        update_i = 1;
        cycle();
        chk("t3_resume", time_o, 24'h000060);

        // 4: pause with prescaler at 2 keeps the partial tick
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_psc == 2) found = 1; else cycle();
        end
        chk("t4_reach", found, 1'b1);
        en_i = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("t4_paused", tick_o, 1'b0);
        end
        en_i = 1;
        cycle(); chk("t4_edge1", tick_o, 1'b0);
        cycle(); chk("t4_edge2", tick_o, 1'b1);

        // 5: clear beats a pending tick
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_psc == 3) found = 1; else cycle();
        end
        chk("t5_reach", found, 1'b1);
        clr_i = 1;
        cycle();
        chk("t5_notick", tick_o, 1'b0);
        chk("t5_time", time_o, 24'h0);
        clr_i = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t5_restart", tick_o, i == 3);
        end

        // 2: full-range rollover from 59:59.95
        preset(FULL - 5);
        en_i = 1; update_i = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (wrap_o) found = 1;
        end
        chk("t2_wrap_seen", found, 1'b1);
        chk("t2_wrap_tick", tick_o, 1'b1);
        cycle();
        chk("t2_time", time_o, 24'h000000);

        // 6: async reset mid-count at 00:01.23
        found = 0;
        for (int i = 0; i < 800 && !found; i++) begin
            cycle();
            if (m_shadow == 123) found = 1;
        end
        chk("t6_reach", found, 1'b1);
        #2 rst = 1;
        #1;
        chk("t6_time", time_o, 24'h0);
        chk("t6_an",   an_o,   6'b111110);
        chk("t6_seg",  seg_o,  7'b1000000);
        chk("t6_dp",   dp_o,   1'b1);
        chk("t6_tick", tick_o, 1'b0);
        @(negedge clk);
        rst = 0;
        model_reset();
        cycle();

        // 7: display scan of 12:34:56
        preset(12 * 6000 + 34 * 100 + 56);
        update_i = 1;
        cycle();
        chk("t7_time", time_o, 24'h123456);
        for (int i = 0; i < 14; i++) cycle();

        // random control mix, starting close to a rollover
        preset(FULL - 60);
        for (int i = 0; i < 3000; i++) begin
            en_i     = ($urandom % 8) != 0;
            update_i = ($urandom % 4) != 0;
            clr_i    = ($urandom % 200) == 0;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
